ahb_lite_bus_monitor: RTL and testbench
=======================================

# ahb_lite_bus_monitor

Passive, parametrised AHB-Lite bus monitor that sits beside the AHB-Lite interface and observes every slave select in the system. It pairs each address phase with its data phase, including wait states and two-cycle error responses, and pushes one record per completed transfer into an internal FIFO. It also keeps saturating transfer, error and drop counters, and checks burst sequencing (SEQ legality, INCR and WRAP address progression, early termination of fixed-length bursts), latching violations in sticky flags. It drives nothing onto the bus.

## Interface
- ADDR_WIDTH, 32, HADDR and record address width
- DATA_WIDTH, 32, HWDATA/HRDATA and record data width; 32 or 64
- NUM_SLAVES, 2, HSEL width; must be ≥2
- FIFO_DEPTH, 8, record FIFO entries; power of two, ≥2
- HCLK  in  1  bus clock; all logic on its rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  NUM_SLAVES  one-hot slave select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
- HWRITE  in  1  write when high
- HSIZE  in  3  transfer size; 1<<HSIZE bytes
- HBURST  in  3  0 = SINGLE, 1 = INCR, 2/3 = WRAP4/INCR4, 4/5 = WRAP8/INCR8, 6/7 = WRAP16/INCR16
- HPROT  in  4  protection; captured in the record
- HWDATA, HRDATA  in  DATA_WIDTH  write and read data
- HREADY  in  1  bus ready
- HRESP  in  1  error response
- clear  in  1  synchronous clear of counters and sticky flags
- rec_valid  out  1  FIFO non-empty
- rec_ready  in  1  pop strobe; pops when rec_valid && rec_ready
- rec_addr  out  ADDR_WIDTH  captured address
- rec_data  out  DATA_WIDTH  HWDATA if write, else HRDATA
- rec_write, rec_err  out  1 each  direction; error response
- rec_size, rec_burst  out  3 each  captured HSIZE and HBURST
- rec_prot  out  4  captured HPROT
- rec_sel  out  $clog2(NUM_SLAVES)  index of the asserted HSEL bit
- xfer_count  out  32  completed transfers, saturating
- err_count, drop_count  out  16 each  error responses and dropped records, saturating
- viol  out  4  sticky violation flags

## Operation
- Address phase is accepted when HREADY=1, HTRANS∈{NONSEQ,SEQ} and |HSEL=1. Control and address are captured into the pending register and pending is set.
- Data phase completes on the first later cycle with HREADY=1. The record is built from the pending register plus the data bus and HRESP, then pushed. Pending is reloaded in the same cycle if a new address phase is accepted.
- Two-cycle error response: the record is pushed on the HRESP=1, HREADY=1 cycle with rec_err=1.
- IDLE and BUSY transfers produce no record. BUSY holds the burst state.
- Burst tracker:
  - A NONSEQ with a fixed-length burst (HBURST≥2) loads remaining = beats−1 and expected address = next beat address.
  - INCR and SINGLE clear remaining; INCR tracks the expected address only.
  - Incrementing next address: addr + (1<<HSIZE), truncated to ADDR_WIDTH.
  - Wrapping next address: bound = beats·(1<<HSIZE); next = (addr & ~(bound−1)) | ((addr + (1<<HSIZE)) & (bound−1)).
  - Each accepted SEQ decrements remaining.
- viol[0]: a SEQ is accepted with no burst active (previous accepted transfer was SINGLE, the last beat of a fixed burst, or none).
- viol[1]: a SEQ address differs from the expected address.
- viol[2]: a NONSEQ or IDLE is accepted while remaining>0. This flag is not set if the preceding data phase ended with an error response.
- viol[3]: more than one HSEL bit is high during an accepted address phase. rec_sel then reports the lowest set bit.
- FIFO push when full without a same-cycle pop: the record is dropped, drop_count increments, and xfer_count still increments.
- FIFO push when full with a same-cycle pop: the push is accepted.
- clear zeroes the counters and viol only. FIFO and pending state are untouched.
- HRESET empties the FIFO and clears pending, the burst tracker, counters and viol. A transfer in its data phase at reset is discarded.

## Timing
- Reset values: rec_valid=0, all rec_* outputs 0, counters 0, viol=0.
- A record pushed at edge N is visible at edge N+1 with rec_valid=1. There is no combinational bypass.
- rec_* outputs show the FIFO head and are registered; the head advances the cycle after a pop.
- Counters and viol update at the same edge as the push or violation detection.
- Priority: HRESET over clear; clear over a same-cycle counter increment, so that cycle's increment is lost.

## Test plan
- Write to 0x100, HSIZE=2, HWDATA=0xA5A5A5A5, no wait states → one cycle later a record: addr 0x100, data 0xA5A5A5A5, write=1, err=0; xfer_count=1.
- WRAP4 word read starting at 0x38 with 2 wait states on beat 2 → four records with addresses 0x38, 0x3C, 0x30, 0x34; viol=0.
- Error response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) on beat 2 of INCR4, followed by NONSEQ → record with err=1; err_count=1; viol[2]=0.
- SEQ after IDLE, then SEQ to a wrong address inside INCR8 → viol[0]=1, viol[1]=1; clear → viol=0.
- FIFO_DEPTH+3 transfers with rec_ready=0 → FIFO_DEPTH records held, drop_count=3, xfer_count=FIFO_DEPTH+3.
- Repeat the previous overflow with pop and push on the same cycle while full → no drop; then assert HRESET mid data phase → rec_valid=0, no record.

Source files
------------

// File: rtl/ahb_lite_bus_monitor_if.sv
// AHB-Lite signal bundle shared by masters, slaves and passive observers.
// The monitor modport sees every signal as an input and drives nothing.
interface ahb_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
);
  logic [NUM_SLAVES-1:0] HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HRESP
  );

  modport monitor (
    input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
          HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_bus_monitor.sv
// Passive AHB-Lite monitor: pairs address and data phases into records held
// in a FIFO, keeps saturating statistics and flags burst sequencing errors.
module ahb_lite_bus_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  ahb_lite_if.monitor                   bus,
  input  logic                          clear,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [ADDR_WIDTH-1:0]         rec_addr,
  output logic [DATA_WIDTH-1:0]         rec_data,
  output logic                          rec_write,
  output logic                          rec_err,
  output logic [2:0]                    rec_size,
  output logic [2:0]                    rec_burst,
  output logic [3:0]                    rec_prot,
  output logic [$clog2(NUM_SLAVES)-1:0] rec_sel,
  output logic [31:0]                   xfer_count,
  output logic [15:0]                   err_count,
  output logic [15:0]                   drop_count,
  output logic [3:0]                    viol
);
  // state   | meaning
  // ST_IDLE | no address phase awaiting its data phase
  // ST_DATA | pending register holds an accepted address phase
  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic                  err;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic [SEL_W-1:0]      sel;
  } rec_t;

  state_t state, state_nxt;
  logic   addr_acc, data_done;
  logic   is_seq, is_nonseq, is_idle, err_now, burst_active;
  logic   [SEL_W-1:0] sel_idx;
  logic   [3:0] v_det;

  rec_t   pend, new_rec, head;
  logic   [3:0] remaining;
  logic   incr_active, last_err;
  logic   [ADDR_WIDTH-1:0] exp_addr;

  rec_t   mem [FIFO_DEPTH];
  logic   [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic   [PTR_W:0]   count, cnt_vis;
  logic   pop, full, push_ok, drop;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            size,
    input logic [2:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step, inc, bound_m1;
    step     = ADDR_WIDTH'(1) << size;
    inc      = a + step;
    bound_m1 = (step << (int'(burst[2:1]) + 1)) - ADDR_WIDTH'(1);
    if (burst[2:1] != 2'd0 && !burst[0])
      return (a & ~bound_m1) | (inc & bound_m1);
    return inc;
  endfunction

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (bus.HSEL[i]) sel_idx = SEL_W'(i);
  end

  assign addr_acc  = bus.HREADY && bus.HTRANS[1] && (|bus.HSEL);
  assign is_seq    = addr_acc && (bus.HTRANS == TR_SEQ);
  assign is_nonseq = addr_acc && (bus.HTRANS == TR_NONSEQ);
  assign is_idle   = bus.HREADY && (bus.HTRANS == TR_IDLE);

  always_comb begin
    state_nxt = state;
    data_done = 1'b0;
    case (state)
      ST_IDLE: if (addr_acc) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bus.HREADY) begin
          data_done = 1'b1;
          state_nxt = addr_acc ? ST_DATA : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      if (addr_acc) begin
        pend.addr  <= bus.HADDR;
        pend.data  <= '0;
        pend.write <= bus.HWRITE;
        pend.err   <= 1'b0;
        pend.size  <= bus.HSIZE;
        pend.burst <= bus.HBURST;
        pend.prot  <= bus.HPROT;
        pend.sel   <= sel_idx;
      end
    end
  end

  assign err_now      = data_done && bus.HRESP;
  assign burst_active = (remaining != 4'd0) || incr_active;

  // An early NONSEQ/IDLE is the legal reaction to an error, so it is excused.
  always_comb begin
    v_det    = 4'd0;
    v_det[0] = is_seq && !burst_active;
    v_det[1] = is_seq && burst_active && (bus.HADDR != exp_addr);
    v_det[2] = (is_nonseq || is_idle) && (remaining != 4'd0) && !(err_now || last_err);
    v_det[3] = addr_acc && (|(bus.HSEL & (bus.HSEL - NUM_SLAVES'(1))));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      remaining   <= 4'd0;
      incr_active <= 1'b0;
      exp_addr    <= '0;
      last_err    <= 1'b0;
    end else begin
      if (data_done) last_err <= bus.HRESP;
      if (is_nonseq) begin
        remaining   <= (bus.HBURST[2:1] != 2'd0) ?
                       4'((5'd2 << bus.HBURST[2:1]) - 5'd1) : 4'd0;
        incr_active <= (bus.HBURST == 3'd1);
        exp_addr    <= next_addr(bus.HADDR, bus.HSIZE, bus.HBURST);
      end else if (is_seq) begin
        if (remaining != 4'd0) remaining <= remaining - 4'd1;
        exp_addr <= next_addr(bus.HADDR, bus.HSIZE, bus.HBURST);
      end else if (is_idle) begin
        remaining   <= 4'd0;
        incr_active <= 1'b0;
      end
    end
  end

  always_comb begin
    new_rec      = pend;
    new_rec.data = pend.write ? bus.HWDATA : bus.HRDATA;
    new_rec.err  = bus.HRESP;
  end

  assign pop     = rec_valid && rec_ready;
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = data_done && (!full || pop);
  assign drop    = data_done && full && !pop;
  assign rd_next = rd_ptr + PTR_W'(pop);
  // Entries written this edge are excluded so a new record appears one cycle later.
  assign cnt_vis = count - (PTR_W+1)'(pop);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rec_valid <= 1'b0;
      head      <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      rec_valid <= (cnt_vis != '0);
      if (cnt_vis != '0) head <= mem[rd_next];
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= new_rec;
  end

  assign rec_addr  = head.addr;
  assign rec_data  = head.data;
  assign rec_write = head.write;
  assign rec_err   = head.err;
  assign rec_size  = head.size;
  assign rec_burst = head.burst;
  assign rec_prot  = head.prot;
  assign rec_sel   = head.sel;

  always_ff @(posedge HCLK) begin
    if (HRESET || clear) begin
      xfer_count <= '0;
      err_count  <= '0;
      drop_count <= '0;
      viol       <= '0;
    end else begin
      if (data_done && xfer_count != '1) xfer_count <= xfer_count + 32'd1;
      if (err_now && err_count != '1)    err_count  <= err_count + 16'd1;
      if (drop && drop_count != '1)      drop_count <= drop_count + 16'd1;
      viol <= viol | v_det;
    end
  end
endmodule

// File: tb/tb_ahb_lite_bus_monitor.sv
// Scoreboard bench for ahb_lite_bus_monitor: expected records are queued as
// data phases are driven and compared as the monitor hands them out.
`timescale 1ns/1ps
module tb_ahb_lite_bus_monitor;
  localparam int AW = 32, DW = 32, NS = 2, DEPTH = 8;
  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  logic          clear, rec_ready, rec_valid, rec_write, rec_err, rec_sel;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_data;
  logic [2:0]    rec_size, rec_burst;
  logic [3:0]    rec_prot, viol;
  logic [31:0]   xfer_count;
  logic [15:0]   err_count, drop_count;

  ahb_lite_bus_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus), .clear(clear),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_write(rec_write),
    .rec_err(rec_err), .rec_size(rec_size), .rec_burst(rec_burst),
    .rec_prot(rec_prot), .rec_sel(rec_sel),
    .xfer_count(xfer_count), .err_count(err_count), .drop_count(drop_count),
    .viol(viol)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          write;
    logic          err;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          sel;
  } rec_t;

  rec_t sb_q[$];
  rec_t exp_rec, tb_pa;
  logic exp_push, tb_pend;
  int   tests, fails, pops;
  int   exp_xfer, exp_err, exp_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pops follow the DUT handshake, pushes model the full/drop rule.
  always @(negedge HCLK) begin
    rec_t e;
    logic was_full, popped;
    if (!HRESET) begin
      was_full = (sb_q.size() == DEPTH);
      popped   = rec_valid && rec_ready;
      if (popped) begin
        if (sb_q.size() == 0) check("unexpected_rec", rec_valid, 1'b0);
        else begin
          e = sb_q.pop_front();
          pops++;
          check("rec_addr",  rec_addr,  e.addr);
          check("rec_data",  rec_data,  e.data);
          check("rec_write", rec_write, e.write);
          check("rec_err",   rec_err,   e.err);
          check("rec_size",  rec_size,  e.size);
          check("rec_burst", rec_burst, e.burst);
          check("rec_prot",  rec_prot,  e.prot);
          check("rec_sel",   rec_sel,   e.sel);
        end
      end
      if (exp_push) begin
        exp_xfer++;
        if (exp_rec.err) exp_err++;
        if (was_full && !popped) exp_drop++;
        else sb_q.push_back(exp_rec);
      end
      if (clear) begin
        exp_xfer = 0;
        exp_err  = 0;
        exp_drop = 0;
      end
    end
  end

  // One bus cycle: drives at posedge+1, returns at the next posedge+1.
  task automatic bus_cycle(input logic [1:0] trans, input logic [1:0] sel,
                           input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [2:0] burst,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic ready, input logic resp);
    bus.HTRANS = trans;  bus.HSEL   = sel;   bus.HADDR  = addr;
    bus.HWRITE = wr;     bus.HSIZE  = size;  bus.HBURST = burst;
    bus.HPROT  = addr[7:4];
    bus.HWDATA = wdata;  bus.HRDATA = rdata;
    bus.HREADY = ready;  bus.HRESP  = resp;
    exp_push = 1'b0;
    if (tb_pend && ready) begin
      exp_rec      = tb_pa;
      exp_rec.data = tb_pa.write ? wdata : rdata;
      exp_rec.err  = resp;
      exp_push     = 1'b1;
    end
    if (ready) begin
      tb_pend = trans[1] && (sel != 2'b00);
      if (tb_pend) begin
        tb_pa.addr  = addr;  tb_pa.data  = '0;    tb_pa.write = wr;
        tb_pa.err   = 1'b0;  tb_pa.size  = size;  tb_pa.burst = burst;
        tb_pa.prot  = addr[7:4];
        tb_pa.sel   = sel[0] ? 1'b0 : 1'b1;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(IDLE, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    rec_ready = 1'b1;
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) idle(1);
    idle(2);
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_valid_after"}, rec_valid, 1'b0);
  endtask

  initial begin
    int p0;
    tests = 0; fails = 0; pops = 0;
    exp_xfer = 0; exp_err = 0; exp_drop = 0;
    exp_push = 1'b0; tb_pend = 1'b0; tb_pa = '0; exp_rec = '0;
    clear = 1'b0; rec_ready = 1'b0; HRESET = 1'b1;
    bus.HSEL = '0; bus.HADDR = '0; bus.HTRANS = IDLE; bus.HWRITE = 1'b0;
    bus.HSIZE = '0; bus.HBURST = '0; bus.HPROT = '0; bus.HWDATA = '0;
    bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    check("rst_valid", rec_valid, 1'b0);
    check("rst_addr", rec_addr, 32'h0);
    check("rst_data", rec_data, 32'h0);
    check("rst_xfer", xfer_count, 32'd0);
    check("rst_err_drop", {err_count, drop_count}, 32'd0);
    check("rst_viol", viol, 4'd0);

    // single write, no wait states
    bus_cycle(NONSEQ, 2'b01, 32'h100, 1'b1, 3'd2, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    bus_cycle(IDLE, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b0);
    check("s1_no_bypass", rec_valid, 1'b0);
    check("s1_xfer", xfer_count, 32'd1);
    idle(1);
    check("s1_valid", rec_valid, 1'b1);
    check("s1_addr", rec_addr, 32'h100);
    check("s1_data", rec_data, 32'hA5A5A5A5);
    check("s1_wr_err", {rec_write, rec_err}, 2'b10);
    drain("s1");

    // WRAP4 word read from 0x38, two wait states on beat 2
    p0 = pops;
    bus_cycle(NONSEQ, 2'b10, 32'h38, 1'b0, 3'd2, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b10, 32'h3C, 1'b0, 3'd2, 3'd2, 32'h0, 32'h11110000, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b10, 32'h30, 1'b0, 3'd2, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    bus_cycle(SEQ,    2'b10, 32'h30, 1'b0, 3'd2, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    bus_cycle(SEQ,    2'b10, 32'h30, 1'b0, 3'd2, 3'd2, 32'h0, 32'h11110001, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b10, 32'h34, 1'b0, 3'd2, 3'd2, 32'h0, 32'h11110002, 1'b1, 1'b0);
    bus_cycle(IDLE,   2'b00, 32'h0,  1'b0, 3'd0, 3'd0, 32'h0, 32'h11110003, 1'b1, 1'b0);
    check("s2_viol", viol, 4'd0);
    drain("s2");
    check("s2_records", 32'(pops - p0), 32'd4);

    // INCR4 write with two-cycle error on beat 2, then NONSEQ
    bus_cycle(NONSEQ, 2'b01, 32'h200, 1'b1, 3'd2, 3'd3, 32'h0, 32'h0, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b01, 32'h204, 1'b1, 3'd2, 3'd3, 32'hC0DE0000, 32'h0, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b01, 32'h208, 1'b1, 3'd2, 3'd3, 32'hC0DE0001, 32'h0, 1'b0, 1'b1);
    bus_cycle(NONSEQ, 2'b01, 32'h300, 1'b1, 3'd2, 3'd0, 32'hC0DE0001, 32'h0, 1'b1, 1'b1);
    bus_cycle(IDLE,   2'b00, 32'h0,   1'b0, 3'd0, 3'd0, 32'hC0DE0002, 32'h0, 1'b1, 1'b0);
    check("s3_err_count", err_count, 16'd1);
    check("s3_viol", viol, 4'd0);
    check("s3_xfer", xfer_count, 32'(exp_xfer));
    drain("s3");

    // SEQ with no burst, wrong SEQ address, early NONSEQ with two selects
    bus_cycle(SEQ,    2'b01, 32'h400, 1'b0, 3'd2, 3'd1, 32'h0, 32'h0, 1'b1, 1'b0);
    bus_cycle(IDLE,   2'b00, 32'h0,   1'b0, 3'd0, 3'd0, 32'h0, 32'h40004000, 1'b1, 1'b0);
    check("s4_viol0", viol, 4'b0001);
    bus_cycle(NONSEQ, 2'b01, 32'h500, 1'b0, 3'd2, 3'd5, 32'h0, 32'h0, 1'b1, 1'b0);
    bus_cycle(SEQ,    2'b01, 32'h504, 1'b0, 3'd2, 3'd5, 32'h0, 32'h50005000, 1'b1, 1'b0);
    check("s4_seq_ok", viol, 4'b0001);
    bus_cycle(SEQ,    2'b01, 32'h50C, 1'b0, 3'd2, 3'd5, 32'h0, 32'h50045004, 1'b1, 1'b0);
    check("s4_viol1", viol, 4'b0011);
    bus_cycle(NONSEQ, 2'b11, 32'h600, 1'b0, 3'd1, 3'd0, 32'h0, 32'h500C500C, 1'b1, 1'b0);
    check("s4_viol23", viol, 4'b1111);
    clear = 1'b1;
    bus_cycle(IDLE,   2'b00, 32'h0,   1'b0, 3'd0, 3'd0, 32'h0, 32'h60006000, 1'b1, 1'b0);
    clear = 1'b0;
    check("s4_clear_viol", viol, 4'd0);
    check("s4_clear_xfer", xfer_count, 32'd0);
    drain("s4");

    // overflow with no consumer
    rec_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < DEPTH + 3; i++)
      bus_cycle(NONSEQ, 2'b01, 32'h800 + 32'(4 * i), 1'b1, 3'd2, 3'd0, 32'hB0000000 + 32'(i), 32'h0, 1'b1, 1'b0);
    bus_cycle(IDLE, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'hB0000000 + 32'(DEPTH + 3), 32'h0, 1'b1, 1'b0);
    check("s5_drop", drop_count, 16'd3);
    check("s5_xfer", xfer_count, 32'(DEPTH + 3));
    check("s5_valid", rec_valid, 1'b1);
    drain("s5");
    check("s5_held", 32'(pops - p0), 32'(DEPTH));

    // overflow again, but popping while full keeps every record
    rec_ready = 1'b0;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rec_ready = (i >= DEPTH + 1);
      bus_cycle(NONSEQ, 2'b10, 32'hA00 + 32'(4 * i), 1'b1, 3'd2, 3'd0, 32'hE0000000 + 32'(i), 32'h0, 1'b1, 1'b0);
    end
    bus_cycle(IDLE, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'hE0000000 + 32'(DEPTH + 3), 32'h0, 1'b1, 1'b0);
    check("s6_drop", drop_count, 16'd0);
    check("s6_xfer", xfer_count, 32'(DEPTH + 3));

    // reset during a waited data phase discards it
    rec_ready = 1'b0;
    bus_cycle(NONSEQ, 2'b01, 32'hC00, 1'b1, 3'd2, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    HRESET = 1'b1;
    tb_pend = 1'b0;
    sb_q.delete();
    exp_xfer = 0; exp_err = 0; exp_drop = 0;
    bus_cycle(IDLE, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0, 32'h12345678, 32'h0, 1'b0, 1'b0);
    HRESET = 1'b0;
    rec_ready = 1'b1;
    idle(4);
    check("s6_rst_valid", rec_valid, 1'b0);
    check("s6_rst_xfer", xfer_count, 32'(exp_xfer));
    check("s6_rst_drop", drop_count, 16'd0);
    check("s6_rst_viol", viol, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
